// File: rtl/div_ctrl.sv
// Issue/writeback controller for the combinational Div array: holds operands for a
// fixed multicycle window while stalling, then captures quotient/remainder into HI/LO.
module div_ctrl #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_sign,
  output logic        div_ena,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               divisor_zero;

  assign divisor_zero = (div_divisor == DATA_W'(0));

  // Single-process FSM; busy/div_ena mirror RUN but are kept as their own flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_sign     <= 1'b0;
      div_ena      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land here; a same-edge issue is later overwritten by its retire.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            div_dividend <= op_a;
            div_divisor  <= op_b;
            div_sign     <= sign;
            count        <= CNT_W'(LATENCY - 1);
            state        <= RUN;
            busy         <= 1'b1;
            div_ena      <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            div_ena <= 1'b0;
          end else if (count != CNT_W'(0)) begin
            count <= count - CNT_W'(1);
          end else begin
            // Retire: a zero divisor leaves HI/LO alone and raises the flag instead.
            state       <= IDLE;
            busy        <= 1'b0;
            div_ena     <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= divisor_zero;
            if (!divisor_zero) begin
              hi <= div_r;
              lo <= div_q;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          div_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule
